cluster_sequencer: RTL and testbench
====================================

// Module: cluster_sequencer
// PURPOSE
//  Iterative controller for the 384-key priority encoder. On each start strobe it captures a
//  vpf/cnt snapshot, repeatedly drives the encoder with a shrinking mask, and extracts up to
//  MXCLUSTERS clusters in ascending key order.
//  Sits between cluster packing (vpf/cnt source) and the cluster output formatter; owns the
//  encoder's vpfs_in/cnts_in/pass_in and consumes its adr/vpf/cnt/pass_out.
// PARAMETERS
//  MXKEYS      384  keys per snapshot
//  MXKEYBITS   9    encoder address width
//  MXCNTB      3    cluster-size bits per key
//  MXCLUSTERS  8    max clusters extracted per snapshot (power of 2, <=16)
//  MXCLSTB     4    width of nclusters, holds 0..MXCLUSTERS
//  TIMEOUT     15   max WAIT cycles before abort
// PORTS
//  clock          in   1                  fabric clock; all logic on posedge
//  reset_n        in   1                  synchronous, active-low reset
//  start          in   1                  1-cycle snapshot strobe, sampled only when busy=0
//  vpfs_in        in   MXKEYS             snapshot valid-pattern flags
//  cnts_in        in   MXKEYS*MXCNTB      snapshot cluster sizes, key k at [k*3+2:k*3]
//  enc_vpfs       out  MXKEYS             to encoder vpfs_in: working mask register
//  enc_cnts       out  MXKEYS*MXCNTB      to encoder cnts_in: captured cnt register
//  enc_pass       out  3                  to encoder pass_in: {issue, iter[1:0]}
//  enc_pass_ret   in   3                  from encoder pass_out
//  enc_adr/vpf/cnt in  MXKEYBITS/1/MXCNTB from encoder result
//  clst_valid     out  1                  1-cycle cluster strobe
//  clst_adr       out  MXKEYBITS          cluster key
//  clst_cnt       out  MXCNTB             cluster size
//  clst_idx       out  log2(MXCLUSTERS)   ordinal within snapshot
//  busy           out  1                  high from cycle after accepted start through done cycle
//  done           out  1                  1-cycle end-of-snapshot strobe
//  nclusters      out  MXCLSTB            clusters emitted, valid with done, held until next start
//  overflow       out  1                  keys remained after MXCLUSTERS, valid with done
//  timeout_err    out  1                  encoder tag never returned, valid with done
//  dropped_starts out  8                  saturating count of starts seen while busy
// BEHAVIOUR
//  Reset: all outputs, mask, cnt register, iter, state = 0 (IDLE); in-flight encoder tags ignored.
//  FSM IDLE->ISSUE->WAIT->(ISSUE|DONE)->IDLE.
//  IDLE: start -> load mask<=vpfs_in, cnt reg<=cnts_in, iter<=0, nclusters/overflow/timeout_err<=0.
//  ISSUE (1 cycle): enc_pass={1,iter[1:0]}; all other cycles enc_pass=0. Mask is frozen ISSUE..response.
//  WAIT: accept response only when enc_pass_ret=={1,iter[1:0]}; mismatched tags ignored.
//   enc_vpf=1: next cycle clst_valid=1, adr/cnt from encoder, idx=iter; mask[enc_adr]<=0;
//     iter++; nclusters++. If iter+1==MXCLUSTERS -> DONE, overflow=|(mask with adr cleared).
//     else -> ISSUE in that same next cycle.
//   enc_vpf=0: -> DONE, no clst_valid.
//   WAIT counter > TIMEOUT cycles -> DONE with timeout_err=1.
//  DONE (1 cycle): done=1, busy=1; may coincide with final clst_valid; -> IDLE.
//  Timing with 2-stage encoder: start @0, ISSUE @1, tag returns @3, clst_valid @4, next ISSUE @4;
//   one cluster per 3 cycles.
//  start while busy: ignored, dropped_starts++ (saturates at 255, cleared only by reset).
//  start coincident with done: dropped (busy=1).
//  reset_n low mid-op: next cycle all outputs 0; any subsequent stale pass tag discarded.
// TESTING
//  bits 5,200,383 set, cnts 3,1,7; start@0 -> clst (5,3,0)@4, (200,1,1)@7, (383,7,2)@10,
//   done@13, nclusters=3, overflow=0.
//  vpfs_in=0 -> done@4, nclusters=0, no clst_valid.
//  bits 0..9 set -> 8 clusters adr 0..7, idx 0..7, last clst_valid and done both @25,
//   nclusters=8, overflow=1.
//  exactly bits 0..7 set -> same timing, overflow=0.
//  start pulsed @2 and @13 during snapshot of test 1 -> both ignored, dropped_starts=2,
//   results unchanged.
//  reset_n=0 @5 of test 1 -> all outputs 0 @6; stale tag @6 ignored; new start @8 with bit 42
//   -> clst (42,..,0)@12.
//  enc_pass_ret forced 0 -> done with timeout_err=1, nclusters=0, 16 cycles after ISSUE.

Source files
------------

// File: rtl/cluster_sequencer.sv
// Iterative extraction controller for the 384-key priority encoder: snapshots vpf/cnt on start,
// then peels off up to MXCLUSTERS clusters in ascending key order by clearing each winner.
module cluster_sequencer #(
    parameter int MXKEYS     = 384,
    parameter int MXKEYBITS  = 9,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8,
    parameter int MXCLSTB    = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [MXKEYS-1:0]          vpfs_in,
    input  logic [MXKEYS*MXCNTB-1:0]   cnts_in,
    output logic [MXKEYS-1:0]          enc_vpfs,
    output logic [MXKEYS*MXCNTB-1:0]   enc_cnts,
    output logic [2:0]                 enc_pass,
    input  logic [2:0]                 enc_pass_ret,
    input  logic [MXKEYBITS-1:0]       enc_adr,
    input  logic                       enc_vpf,
    input  logic [MXCNTB-1:0]          enc_cnt,
    output logic                       clst_valid,
    output logic [MXKEYBITS-1:0]       clst_adr,
    output logic [MXCNTB-1:0]          clst_cnt,
    output logic [$clog2(MXCLUSTERS)-1:0] clst_idx,
    output logic                       busy,
    output logic                       done,
    output logic [MXCLSTB-1:0]         nclusters,
    output logic                       overflow,
    output logic                       timeout_err,
    output logic [7:0]                 dropped_starts
);

    localparam int IDXB = $clog2(MXCLUSTERS);
    localparam int WCB  = $clog2(TIMEOUT + 1);
    localparam logic [MXKEYBITS-1:0] LAST_KEY  = MXKEYBITS'(MXKEYS - 1);
    localparam logic [MXCLSTB-1:0]   LAST_ITER = MXCLSTB'(MXCLUSTERS - 1);
    localparam logic [WCB-1:0]       WAIT_LIM  = WCB'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_r, state_s;
    logic [MXKEYS-1:0]       mask_r, mask_s, clr_mask_s;
    logic [MXKEYS*MXCNTB-1:0] cnt_r, cnt_s;
    logic [MXCLSTB-1:0]      iter_r, iter_s;
    logic [WCB-1:0]          wcnt_r, wcnt_s;
    logic [2:0]              pass_r, pass_s;
    logic                    cv_r, cv_s;
    logic [MXKEYBITS-1:0]    cadr_r, cadr_s;
    logic [MXCNTB-1:0]       ccnt_r, ccnt_s;
    logic [IDXB-1:0]         cidx_r, cidx_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    ovf_r, ovf_s;
    logic                    tmo_r, tmo_s;
    logic [7:0]              drop_r, drop_s;
    logic                    tag_match_s;

    // Next-state, datapath updates and registered-output precomputation.
    always_comb begin
        state_s    = state_r;
        mask_s     = mask_r;
        cnt_s      = cnt_r;
        iter_s     = iter_r;
        wcnt_s     = wcnt_r;
        cv_s       = 1'b0;
        cadr_s     = cadr_r;
        ccnt_s     = ccnt_r;
        cidx_s     = cidx_r;
        ovf_s      = ovf_r;
        tmo_s      = tmo_r;
        drop_s     = drop_r;
        clr_mask_s = mask_r;
        tag_match_s = (enc_pass_ret == {1'b1, iter_r[1:0]});

        if (enc_adr <= LAST_KEY) begin
            clr_mask_s[enc_adr] = 1'b0;
        end else begin
            clr_mask_s = mask_r;
        end

        case (state_r)
            IDLE: begin
                if (start) begin
                    mask_s  = vpfs_in;
                    cnt_s   = cnts_in;
                    iter_s  = '0;
                    ovf_s   = 1'b0;
                    tmo_s   = 1'b0;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                wcnt_s  = '0;
                state_s = WAIT;
            end
            WAIT: begin
                if (tag_match_s) begin
                    if (enc_vpf) begin
                        cv_s   = 1'b1;
                        cadr_s = enc_adr;
                        ccnt_s = enc_cnt;
                        cidx_s = iter_r[IDXB-1:0];
                        mask_s = clr_mask_s;
                        iter_s = iter_r + MXCLSTB'(1);
                        if (iter_r == LAST_ITER) begin
                            ovf_s   = |clr_mask_s;
                            state_s = DONE;
                        end else begin
                            state_s = ISSUE;
                        end
                    end else begin
                        state_s = DONE;
                    end
                end else if (wcnt_r >= WAIT_LIM) begin
                    tmo_s   = 1'b1;
                    state_s = DONE;
                end else begin
                    wcnt_s = wcnt_r + WCB'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // busy_r already covers the done cycle, so a start there is counted as dropped.
        if (start && busy_r && (drop_r != 8'hFF)) begin
            drop_s = drop_r + 8'd1;
        end else begin
            drop_s = drop_r;
        end

        pass_s = (state_s == ISSUE) ? {1'b1, iter_s[1:0]} : 3'b000;
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= IDLE;
            mask_r  <= '0;
            cnt_r   <= '0;
            iter_r  <= '0;
            wcnt_r  <= '0;
            pass_r  <= 3'b000;
            cv_r    <= 1'b0;
            cadr_r  <= '0;
            ccnt_r  <= '0;
            cidx_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            tmo_r   <= 1'b0;
            drop_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            mask_r  <= mask_s;
            cnt_r   <= cnt_s;
            iter_r  <= iter_s;
            wcnt_r  <= wcnt_s;
            pass_r  <= pass_s;
            cv_r    <= cv_s;
            cadr_r  <= cadr_s;
            ccnt_r  <= ccnt_s;
            cidx_r  <= cidx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ovf_r   <= ovf_s;
            tmo_r   <= tmo_s;
            drop_r  <= drop_s;
        end
    end

    assign enc_vpfs       = mask_r;
    assign enc_cnts       = cnt_r;
    assign enc_pass       = pass_r;
    assign clst_valid     = cv_r;
    assign clst_adr       = cadr_r;
    assign clst_cnt       = ccnt_r;
    assign clst_idx       = cidx_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign nclusters      = iter_r;
    assign overflow       = ovf_r;
    assign timeout_err    = tmo_r;
    assign dropped_starts = drop_r;

endmodule

// File: tb/tb_cluster_sequencer.sv
// Directed bench for cluster_sequencer with a 2-stage lowest-key-first priority encoder model.
module tb_cluster_sequencer;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [383:0]  vpfs_in = '0;
    logic [1151:0] cnts_in = '0;
    logic [383:0]  enc_vpfs;
    logic [1151:0] enc_cnts;
    logic [2:0]    enc_pass, enc_pass_ret;
    logic [8:0]    enc_adr;
    logic          enc_vpf;
    logic [2:0]    enc_cnt;
    logic          clst_valid;
    logic [8:0]    clst_adr;
    logic [2:0]    clst_cnt;
    logic [2:0]    clst_idx;
    logic          busy, done, overflow, timeout_err;
    logic [3:0]    nclusters;
    logic [7:0]    dropped_starts;

    int tests = 0;
    int fails = 0;

    cluster_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .vpfs_in(vpfs_in), .cnts_in(cnts_in),
        .enc_vpfs(enc_vpfs), .enc_cnts(enc_cnts), .enc_pass(enc_pass),
        .enc_pass_ret(enc_pass_ret), .enc_adr(enc_adr), .enc_vpf(enc_vpf), .enc_cnt(enc_cnt),
        .clst_valid(clst_valid), .clst_adr(clst_adr), .clst_cnt(clst_cnt), .clst_idx(clst_idx),
        .busy(busy), .done(done), .nclusters(nclusters), .overflow(overflow),
        .timeout_err(timeout_err), .dropped_starts(dropped_starts)
    );

    always #5 clock = ~clock;

    // Encoder model: lowest set key wins; two register stages, not reset by the DUT reset.
    int       lo;
    logic     force_zero = 1'b0;
    logic [2:0] s1_pass = '0, s2_pass = '0;
    logic     s1_vpf = 1'b0, s2_vpf = 1'b0;
    logic [8:0] s1_adr = '0, s2_adr = '0;
    logic [2:0] s1_cnt = '0, s2_cnt = '0;

    always_comb begin
        lo = 0;
        for (int k = 383; k >= 0; k--) begin
            if (enc_vpfs[k]) lo = k;
        end
    end

    always_ff @(posedge clock) begin
        s1_pass <= enc_pass;
        s1_vpf  <= |enc_vpfs;
        s1_adr  <= 9'(lo);
        s1_cnt  <= enc_cnts[lo*3 +: 3];
        s2_pass <= s1_pass;
        s2_vpf  <= s1_vpf;
        s2_adr  <= s1_adr;
        s2_cnt  <= s1_cnt;
    end

    assign enc_pass_ret = force_zero ? 3'b000 : s2_pass;
    assign enc_vpf = s2_vpf;
    assign enc_adr = s2_adr;
    assign enc_cnt = s2_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int nev, done_cyc, busy1;
    int ev_cyc[16], ev_adr[16], ev_cnt[16], ev_idx[16];

    // Strobe start at relative cycle 0, optionally re-pulse it at d1/d2, record until done.
    task automatic run_snapshot(input logic [383:0] v, input logic [1151:0] c,
                                input int d1, input int d2);
        int cyc;
        nev = 0; done_cyc = -1; busy1 = -1; cyc = 0;
        vpfs_in = v; cnts_in = c; start = 1'b1;
        while (cyc < 100) begin
            tick();
            cyc++;
            start = (cyc == d1 || cyc == d2);
            if (cyc == 1) busy1 = int'(busy);
            if (clst_valid && nev < 16) begin
                ev_cyc[nev] = cyc; ev_adr[nev] = int'(clst_adr);
                ev_cnt[nev] = int'(clst_cnt); ev_idx[nev] = int'(clst_idx);
                nev++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) chk("done_bound", 32'd0, 32'd1);
        tick();
        start = 1'b0;
    endtask

    logic [383:0]  v;
    logic [1151:0] c;

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(enc_pass), 32'd0);
        chk("rst_mask", 32'(|enc_vpfs), 32'd0);
        chk("rst_drop", 32'(dropped_starts), 32'd0);

        // Test 1: keys 5, 200, 383
        v = '0; c = '0;
        v[5] = 1'b1;   c[5*3 +: 3]   = 3'd3;
        v[200] = 1'b1; c[200*3 +: 3] = 3'd1;
        v[383] = 1'b1; c[383*3 +: 3] = 3'd7;
        run_snapshot(v, c, -1, -1);
        chk("t1_busy1", 32'(busy1), 32'd1);
        chk("t1_nev", 32'(nev), 32'd3);
        chk("t1_c0", 32'(ev_cyc[0]), 32'd4);  chk("t1_a0", 32'(ev_adr[0]), 32'd5);
        chk("t1_n0", 32'(ev_cnt[0]), 32'd3);  chk("t1_i0", 32'(ev_idx[0]), 32'd0);
        chk("t1_c1", 32'(ev_cyc[1]), 32'd7);  chk("t1_a1", 32'(ev_adr[1]), 32'd200);
        chk("t1_n1", 32'(ev_cnt[1]), 32'd1);  chk("t1_i1", 32'(ev_idx[1]), 32'd1);
        chk("t1_c2", 32'(ev_cyc[2]), 32'd10); chk("t1_a2", 32'(ev_adr[2]), 32'd383);
        chk("t1_n2", 32'(ev_cnt[2]), 32'd7);  chk("t1_i2", 32'(ev_idx[2]), 32'd2);
        chk("t1_done", 32'(done_cyc), 32'd13);
        chk("t1_ncl", 32'(nclusters), 32'd3);
        chk("t1_ovf", 32'(overflow), 32'd0);
        chk("t1_tmo", 32'(timeout_err), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Test 1 again with starts at cycles 2 and 13 (the done cycle): both dropped
        run_snapshot(v, c, 2, 13);
        chk("dr_nev", 32'(nev), 32'd3);
        chk("dr_a2", 32'(ev_adr[2]), 32'd383);
        chk("dr_c2", 32'(ev_cyc[2]), 32'd10);
        chk("dr_done", 32'(done_cyc), 32'd13);
        chk("dr_ncl", 32'(nclusters), 32'd3);
        chk("dr_cnt", 32'(dropped_starts), 32'd2);
        chk("dr_idle", 32'(busy), 32'd0);

        // Test 2: empty snapshot
        run_snapshot('0, '0, -1, -1);
        chk("t2_nev", 32'(nev), 32'd0);
        chk("t2_done", 32'(done_cyc), 32'd4);
        chk("t2_ncl", 32'(nclusters), 32'd0);

        // Test 3: keys 0..9 -> 8 clusters, overflow
        v = '0; c = '0;
        for (int k = 0; k < 10; k++) begin
            v[k] = 1'b1;
            c[k*3 +: 3] = 3'(7 - (k % 8));
        end
        run_snapshot(v, c, -1, -1);
        chk("t3_nev", 32'(nev), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_c%0d", i), 32'(ev_cyc[i]), 32'(4 + 3 * i));
            chk($sformatf("t3_a%0d", i), 32'(ev_adr[i]), 32'(i));
            chk($sformatf("t3_i%0d", i), 32'(ev_idx[i]), 32'(i));
            chk($sformatf("t3_n%0d", i), 32'(ev_cnt[i]), 32'(7 - i));
        end
        chk("t3_done", 32'(done_cyc), 32'd25);
        chk("t3_ncl", 32'(nclusters), 32'd8);
        chk("t3_ovf", 32'(overflow), 32'd1);

        // Test 4: exactly keys 0..7 -> no overflow
        v[8] = 1'b0; v[9] = 1'b0;
        run_snapshot(v, c, -1, -1);
        chk("t4_nev", 32'(nev), 32'd8);
        chk("t4_c7", 32'(ev_cyc[7]), 32'd25);
        chk("t4_done", 32'(done_cyc), 32'd25);
        chk("t4_ncl", 32'(nclusters), 32'd8);
        chk("t4_ovf", 32'(overflow), 32'd0);

        // Reset mid-snapshot: start @0 with test 1 data, reset_n low during cycle 5
        v = '0; c = '0;
        v[5] = 1'b1;   c[5*3 +: 3]   = 3'd3;
        v[200] = 1'b1; c[200*3 +: 3] = 3'd1;
        v[383] = 1'b1; c[383*3 +: 3] = 3'd7;
        vpfs_in = v; cnts_in = c; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_cv", 32'(clst_valid), 32'd0);
        chk("rs_pass", 32'(enc_pass), 32'd0);
        chk("rs_mask", 32'(|enc_vpfs), 32'd0);
        chk("rs_ncl", 32'(nclusters), 32'd0);
        chk("rs_drop", 32'(dropped_starts), 32'd0);
        tick();
        chk("rs_stale_busy", 32'(busy), 32'd0);
        chk("rs_stale_cv", 32'(clst_valid), 32'd0);
        tick();
        v = '0; c = '0;
        v[42] = 1'b1; c[42*3 +: 3] = 3'd5;
        run_snapshot(v, c, -1, -1);
        chk("rs_nev", 32'(nev), 32'd1);
        chk("rs_c0", 32'(ev_cyc[0]), 32'd4);
        chk("rs_a0", 32'(ev_adr[0]), 32'd42);
        chk("rs_n0", 32'(ev_cnt[0]), 32'd5);
        chk("rs_i0", 32'(ev_idx[0]), 32'd0);
        chk("rs_done", 32'(done_cyc), 32'd7);

        // Timeout: encoder tag never returns
        force_zero = 1'b1;
        v = '0; c = '0; v[3] = 1'b1;
        run_snapshot(v, c, -1, -1);
        chk("to_nev", 32'(nev), 32'd0);
        chk("to_done", 32'(done_cyc), 32'd17);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_ncl", 32'(nclusters), 32'd0);
        force_zero = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
